// File: rtl/lap_record_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lap_record_reader : DEPTH-slot lap ring buffer with prev/next recall        |
// | Optional: LAP_OVERWRITE_EN (record while full replaces the oldest lap)      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lap_record_reader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_core,
  input  logic              rst,
  input  logic              record,
  input  logic [5:0]        min_i,
  input  logic [5:0]        sec_i,
  input  logic [6:0]        ms_10_i,
  input  logic              clear,
  input  logic              prev,
  input  logic              next,
  output logic [5:0]        min_o,
  output logic [5:0]        sec_o,
  output logic [6:0]        ms_10_o,
  output logic [ADDR_W-1:0] lap_idx_o,
  output logic [ADDR_W:0]   lap_count_o,
  output logic              valid_o,
  output logic              full_o
);

  localparam int               C_ENTRY_W = 19;
  localparam logic [ADDR_W:0]  C_FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(DEPTH - 1);

  logic [C_ENTRY_W-1:0] mem_q [DEPTH];
  logic [C_ENTRY_W-1:0] data_q;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_base_q, rd_base_d;
  logic [ADDR_W-1:0]    cur_q, cur_d;
  logic [ADDR_W:0]      cnt_q, cnt_d;
  logic                 prev_q, next_q;
  logic                 valid_q, full_q;

  logic                 w_step_prev, w_step_next, w_full, w_wr_en;
  logic [ADDR_W-1:0]    w_last, w_rd_addr;

  assign w_step_prev = prev & ~prev_q;
  assign w_step_next = next & ~next_q;
  assign w_full      = (cnt_q == C_FULL);
  // Low bits of cnt minus one wraps DEPTH to DEPTH-1 for free
  assign w_last      = cnt_q[ADDR_W-1:0] - 1'b1;
  assign w_rd_addr   = rd_base_q + cur_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_base_d = rd_base_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    w_wr_en   = 1'b0;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_base_d = '0;
      cur_d     = '0;
      cnt_d     = '0;
    end else if (record) begin
      if (!w_full) begin
        w_wr_en  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        cur_d    = cnt_q[ADDR_W-1:0];
      end else begin
`ifdef LAP_OVERWRITE_EN
        w_wr_en   = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        rd_base_d = rd_base_q + 1'b1;
        cur_d     = C_LAST;
`endif
      end
    end else if (cnt_q != '0 && w_step_prev && !w_step_next) begin
      cur_d = (cur_q == '0) ? w_last : cur_q - 1'b1;
    end else if (cnt_q != '0 && w_step_next && !w_step_prev) begin
      cur_d = (cur_q == w_last) ? '0 : cur_q + 1'b1;
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_q    <= '0;
      wr_ptr_q  <= '0;
      rd_base_q <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      next_q    <= 1'b0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      if (w_wr_en) mem_q[wr_ptr_q] <= {min_i, sec_i, ms_10_i};
      data_q    <= (cnt_q == '0) ? '0 : mem_q[w_rd_addr];
      wr_ptr_q  <= wr_ptr_d;
      rd_base_q <= rd_base_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev;
      next_q    <= next;
      valid_q   <= (cnt_d != '0);
      full_q    <= (cnt_d == C_FULL);
    end
  end

  assign min_o       = data_q[18:13];
  assign sec_o       = data_q[12:7];
  assign ms_10_o     = data_q[6:0];
  assign lap_idx_o   = cur_q;
  assign lap_count_o = cnt_q;
  assign valid_o     = valid_q;
  assign full_o      = full_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_record_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lap_record_reader : directed self-checking bench for lap_record_reader   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_lap_record_reader;

  logic       clk_core = 1'b0;
  logic       rst;
  logic       record, clear, prev, next;
  logic [5:0] min_i, sec_i;
  logic [6:0] ms_10_i;
  logic [5:0] min_o, sec_o;
  logic [6:0] ms_10_o;
  logic [2:0] lap_idx_o;
  logic [3:0] lap_count_o;
  logic       valid_o, full_o;

  int n_tests = 0;
  int n_fail  = 0;

  lap_record_reader #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk_core(clk_core), .rst(rst), .record(record),
    .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
    .clear(clear), .prev(prev), .next(next),
    .min_o(min_o), .sec_o(sec_o), .ms_10_o(ms_10_o),
    .lap_idx_o(lap_idx_o), .lap_count_o(lap_count_o),
    .valid_o(valid_o), .full_o(full_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_core);
      #1;
    end
  endtask

  task automatic rec(input logic [5:0] m, input logic [5:0] s, input logic [6:0] ms);
    record = 1'b1; min_i = m; sec_i = s; ms_10_i = ms;
    tick();
    record = 1'b0;
  endtask

  task automatic pulse_prev();
    prev = 1'b1; tick(); prev = 1'b0; tick();
  endtask

  task automatic pulse_next();
    next = 1'b1; tick(); next = 1'b0; tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0; record = 0; clear = 0; prev = 0; next = 0;
    min_i = 0; sec_i = 0; ms_10_i = 0;
    tick(3);
    rst = 1'b1;
    tick(10);
    check("rst_min", min_o, 0);
    check("rst_sec", sec_o, 0);
    check("rst_ms", ms_10_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_full", full_o, 0);
    check("rst_count", lap_count_o, 0);
    pulse_prev();
    pulse_next();
    check("empty_step_idx", lap_idx_o, 0);

    // three laps
    rec(0, 5, 10);
    rec(0, 12, 34);
    rec(1, 0, 99);
    check("rec3_count", lap_count_o, 3);
    check("rec3_idx", lap_idx_o, 2);
    check("rec3_valid", valid_o, 1);
    tick();
    check("rec3_min", min_o, 1);
    check("rec3_sec", sec_o, 0);
    check("rec3_ms", ms_10_o, 99);

    // navigation with wrap
    prev = 1; tick(); check("prev1_idx", lap_idx_o, 1); prev = 0; tick();
    check("prev1_sec", sec_o, 12);
    prev = 1; tick(); check("prev2_idx", lap_idx_o, 0); prev = 0; tick();
    prev = 1; tick(); check("prev3_wrap", lap_idx_o, 2); prev = 0; tick();
    next = 1; tick(); check("next_wrap", lap_idx_o, 0); next = 0; tick();
    check("idx0_min", min_o, 0);
    check("idx0_sec", sec_o, 5);
    check("idx0_ms", ms_10_o, 10);
    prev = 1; tick(20); prev = 0; tick();
    check("hold_prev_idx", lap_idx_o, 2);

    // record + prev collision, then clear + record
    do_clear();
    check("clear_count", lap_count_o, 0);
    check("clear_valid", valid_o, 0);
    tick();
    check("clear_sec", sec_o, 0);
    rec(0, 1, 1);
    rec(0, 2, 2);
    check("pre_coll_count", lap_count_o, 2);
    prev = 1; rec(0, 3, 3); prev = 0;
    check("coll_count", lap_count_o, 3);
    check("coll_idx", lap_idx_o, 2);
    tick();
    check("coll_sec", sec_o, 3);
    clear = 1; rec(0, 4, 4); clear = 0;
    check("clr_rec_count", lap_count_o, 0);
    check("clr_rec_valid", valid_o, 0);

    // overflow: nine laps into eight slots
    for (int i = 0; i < 9; i++) rec(0, 6'(i), 0);
    check("ovf_count", lap_count_o, 8);
    check("ovf_full", full_o, 1);
    check("ovf_idx", lap_idx_o, 7);
    tick();
`ifdef LAP_OVERWRITE_EN
    check("ovf_newest_sec", sec_o, 8);
    pulse_next();
    check("ovf_wrap_idx", lap_idx_o, 0);
    check("ovf_oldest_sec", sec_o, 1);
`else
    check("ovf_newest_sec", sec_o, 7);
    pulse_next();
    check("ovf_wrap_idx", lap_idx_o, 0);
    check("ovf_oldest_sec", sec_o, 0);
`endif
    check("ovf_full_hold", full_o, 1);

    // asynchronous reset mid-sequence
    do_clear();
    for (int i = 0; i < 5; i++) rec(0, 6'(i + 1), 7'(i + 20));
    tick();
    check("pre_rst_count", lap_count_o, 5);
    check("pre_rst_sec", sec_o, 5);
    #2 rst = 1'b0;
    #1;
    check("async_count", lap_count_o, 0);
    check("async_sec", sec_o, 0);
    check("async_ms", ms_10_o, 24 - 24);
    check("async_valid", valid_o, 0);
    tick();
    rst = 1'b1;
    tick();
    rec(2, 3, 4);
    check("post_rst_count", lap_count_o, 1);
    check("post_rst_idx", lap_idx_o, 0);
    tick();
    check("post_rst_min", min_o, 2);
    check("post_rst_ms", ms_10_o, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
